cpu_clock_control: RTL and testbench

Run/stop/single-step controller that sits directly downstream of the CPU clock divider.
- Samples the divider's active-low tick (low for one `clk_in` cycle every DIVISOR cycles) and converts it into a one-cycle CPU clock-enable.
- Gates that enable according to a HALTED / RUNNING / STEP_ARMED state machine driven by two debounced push-buttons and a CPU halt request.
- Counts delivered CPU cycles for the debug display.

---
 rtl/cpu_clock_control.sv | 178 +++++++++++++++++
 tb/tb_cpu_clock_control.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_control.sv
// cpu_clock_control
//
// Run/stop/single-step controller placed after the CPU clock divider. It turns
// the divider's active-low one-cycle tick into a one-cycle CPU clock-enable and
// gates it with a HALTED / RUNNING / STEP_ARMED state machine. Two push-buttons
// (run/stop and step) are synchronised and debounced here. The CPU can halt
// itself with halt_req. Delivered CPU cycles are counted for a debug display.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a button level
//                    change (legal 2..2^20-1)
//   START_RUNNING    1: leave reset in RUNNING, 0: leave reset in HALTED
//
// Ports:
//   clk_in        in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   tick_n        in   divider tick, low for one clk_in cycle per period
//   btn_run_stop  in   raw run/stop button, active high, bouncy, asynchronous
//   btn_step      in   raw single-step button, active high, bouncy, asynchronous
//   halt_req      in   one-cycle halt request from the CPU
//   cpu_clk_en    out  registered one-cycle CPU clock-enable
//   running       out  high while RUNNING
//   step_pending  out  high while STEP_ARMED
//   cycle_count   out  number of cpu_clk_en pulses since reset, wraps

module cpu_clock_control #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic        START_RUNNING   = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick_n,
  input  logic        btn_run_stop,
  input  logic        btn_step,
  input  logic        halt_req,
  output logic        cpu_clk_en,
  output logic        running,
  output logic        step_pending,
  output logic [31:0] cycle_count
);

  // Button index 0 is run/stop, index 1 is step.
  localparam int unsigned NumBtn = 2;
  localparam int unsigned BtnRun = 0;
  localparam int unsigned BtnStep = 1;

  localparam logic [19:0] DebounceLast = DEBOUNCE_CYCLES - 20'd1;

  typedef enum logic [1:0] {
    StHalted,
    StRunning,
    StStepArmed
  } state_e;

  localparam state_e ResetState = START_RUNNING ? StRunning : StHalted;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] s1_q;
  logic [NumBtn-1:0] s2_q;
  logic [NumBtn-1:0] stable_q;
  logic [NumBtn-1:0] press_q;
  logic [19:0]       cnt_q [NumBtn];

  assign btn_raw = {btn_step, btn_run_stop};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
      for (int i = 0; i < NumBtn; i++) begin
        press_q[i] <= 1'b0;
        if (s2_q[i] == stable_q[i]) begin
          // Any sample agreeing with the accepted level restarts the count,
          // so a glitch shorter than DEBOUNCE_CYCLES never gets through.
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DebounceLast) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= '0;
          // Pulse only on an accepted 0->1 change; releases are silent.
          press_q[i]  <= s2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 20'd1;
        end
      end
    end
  end

  logic run_press;
  logic step_press;
  logic tick;

  assign run_press  = press_q[BtnRun];
  assign step_press = press_q[BtnStep];
  assign tick       = ~tick_n;

  // ---------------------------------------------------------------------------
  // Run / stop / step state machine, enable and cycle counter
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic        cpu_clk_en_q;
  logic        running_q;
  logic        step_pending_q;
  logic [31:0] cycle_count_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ResetState;
      running_q      <= START_RUNNING;
      step_pending_q <= 1'b0;
      cpu_clk_en_q   <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      cpu_clk_en_q <= 1'b0;
      unique case (state_q)
        StHalted: begin
          // Ticks are ignored while halted.
          if (run_press) begin
            state_q        <= StRunning;
            running_q      <= 1'b1;
            step_pending_q <= 1'b0;
          end else if (step_press) begin
            state_q        <= StStepArmed;
            running_q      <= 1'b0;
            step_pending_q <= 1'b1;
          end
        end
        StStepArmed: begin
          // Run press wins over the pending step, which is then dropped.
          if (run_press) begin
            state_q        <= StRunning;
            running_q      <= 1'b1;
            step_pending_q <= 1'b0;
          end else if (tick) begin
            cpu_clk_en_q   <= 1'b1;
            cycle_count_q  <= cycle_count_q + 32'd1;
            state_q        <= StHalted;
            running_q      <= 1'b0;
            step_pending_q <= 1'b0;
          end
        end
        StRunning: begin
          // halt_req only matters here, so single-stepping past a breakpoint
          // is not re-trapped.
          if (halt_req || run_press) begin
            state_q        <= StHalted;
            running_q      <= 1'b0;
            step_pending_q <= 1'b0;
          end else if (tick) begin
            cpu_clk_en_q  <= 1'b1;
            cycle_count_q <= cycle_count_q + 32'd1;
          end
        end
        default: begin
          state_q        <= StHalted;
          running_q      <= 1'b0;
          step_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_clk_en   = cpu_clk_en_q;
  assign running      = running_q;
  assign step_pending = step_pending_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_control.sv
// Bench for cpu_clock_control with DEBOUNCE_CYCLES=4 and a tick every 10
// cycles. A behavioural model predicts every output each cycle: buttons are
// modelled as a two-cycle delay plus a "last D samples all differ from the
// accepted level" window, the controller as a table of the run/stop/step rules.

module tb_cpu_clock_control;

  localparam int Deb = 4;
  localparam int MHalted = 0;
  localparam int MRun = 1;
  localparam int MStep = 2;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_n = 1'b1;
  logic        btn_run_stop = 1'b0;
  logic        btn_step = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_clk_en;
  logic        running;
  logic        step_pending;
  logic [31:0] cycle_count;

  cpu_clock_control #(
    .DEBOUNCE_CYCLES(20'd4),
    .START_RUNNING  (1'b0)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .tick_n      (tick_n),
    .btn_run_stop(btn_run_stop),
    .btn_step    (btn_step),
    .halt_req    (halt_req),
    .cpu_clk_en  (cpu_clk_en),
    .running     (running),
    .step_pending(step_pending),
    .cycle_count (cycle_count)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int tcnt = 0;

  // Model state
  int          mstate;
  logic        men;
  logic [31:0] mcount;
  logic        mpress [2];
  logic        mstable [2];
  logic        mpipe [2][2];   // [button][0]=first flop, [1]=second flop
  logic        mhist [2][Deb]; // last Deb samples of the synchronised level

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".en"}, {31'd0, cpu_clk_en}, {31'd0, men});
    check_eq({tag, ".running"}, {31'd0, running}, {31'd0, mstate == MRun});
    check_eq({tag, ".step_pending"}, {31'd0, step_pending}, {31'd0, mstate == MStep});
    check_eq({tag, ".count"}, cycle_count, mcount);
  endtask

  task automatic model_reset();
    mstate = MHalted;
    men    = 1'b0;
    mcount = '0;
    for (int b = 0; b < 2; b++) begin
      mpress[b]   = 1'b0;
      mstable[b]  = 1'b0;
      mpipe[b][0] = 1'b0;
      mpipe[b][1] = 1'b0;
      for (int k = 0; k < Deb; k++) mhist[b][k] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge, given the inputs of the cycle.
  task automatic model_step(input logic run, input logic step, input logic halt,
                            input logic tkn);
    logic tick;
    logic raw [2];
    logic all_diff;
    tick = !tkn;
    raw[0] = run;
    raw[1] = step;
    men = 1'b0;
    // Priority: halt_req > run press > step press > tick.
    if (mstate == MRun) begin
      if (halt || mpress[0]) mstate = MHalted;
      else if (tick) men = 1'b1;
    end else if (mstate == MStep) begin
      if (mpress[0]) mstate = MRun;
      else if (tick) begin
        men = 1'b1;
        mstate = MHalted;
      end
    end else begin
      if (mpress[0]) mstate = MRun;
      else if (mpress[1]) mstate = MStep;
    end
    if (men) mcount = mcount + 32'd1;
    for (int b = 0; b < 2; b++) begin
      for (int k = Deb - 1; k > 0; k--) mhist[b][k] = mhist[b][k-1];
      mhist[b][0] = mpipe[b][1];
      all_diff = 1'b1;
      for (int k = 0; k < Deb; k++) if (mhist[b][k] == mstable[b]) all_diff = 1'b0;
      mpress[b] = 1'b0;
      if (all_diff) begin
        mstable[b] = ~mstable[b];
        mpress[b]  = mstable[b];
      end
      mpipe[b][1] = mpipe[b][0];
      mpipe[b][0] = raw[b];
    end
  endtask

  task automatic cycle(input logic run, input logic step, input logic halt);
    btn_run_stop = run;
    btn_step     = step;
    halt_req     = halt;
    tick_n       = (tcnt == 9) ? 1'b0 : 1'b1;
    tcnt         = (tcnt + 1) % 10;
    @(posedge clk_in);
    if (rst_n) model_step(run, step, halt, tick_n);
    #1;
    compare_all("cyc");
  endtask

  task automatic run_cycles(input int n, input logic run, input logic step, input logic halt);
    for (int i = 0; i < n; i++) cycle(run, step, halt);
  endtask

  // Asynchronous assert mid-cycle, synchronous release on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  logic r_lvl, s_lvl, h_prev;
  int   r_hold, s_hold;

  initial begin
    model_reset();
    #1;
    compare_all("por");
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Halted: ticks alone never enable.
    run_cycles(100, 1'b0, 1'b0, 1'b0);
    check_eq("halted_count", cycle_count, 32'd0);

    // Clean run press, then five ticks.
    run_cycles(8, 1'b1, 1'b0, 1'b0);
    run_cycles(50, 1'b0, 1'b0, 1'b0);
    check_eq("run_count", cycle_count, mcount);

    // Stop, then a bouncy step press.
    run_cycles(8, 1'b1, 1'b0, 1'b0);
    run_cycles(12, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      run_cycles(3, 1'b0, 1'b1, 1'b0);
      run_cycles(2, 1'b0, 1'b0, 1'b0);
    end
    run_cycles(20, 1'b0, 1'b1, 1'b0);
    run_cycles(20, 1'b0, 1'b0, 1'b0);

    // Running: halt_req coinciding with a tick.
    run_cycles(8, 1'b1, 1'b0, 1'b0);
    run_cycles(12, 1'b0, 1'b0, 1'b0);
    while (tcnt != 9) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("halt_tick_en", {31'd0, cpu_clk_en}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("halt_running", {31'd0, running}, 32'd0);
    run_cycles(8, 1'b0, 1'b1, 1'b0);
    run_cycles(20, 1'b0, 1'b0, 1'b0);

    // Counter wrap.
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count_q;
    mcount = 32'hFFFF_FFFF;
    run_cycles(8, 1'b0, 1'b1, 1'b0);
    run_cycles(20, 1'b0, 1'b0, 1'b0);
    check_eq("wrap", cycle_count, 32'd0);

    // Reset while STEP_ARMED with a run press mid-debounce.
    while (tcnt != 0) cycle(1'b0, 1'b0, 1'b0);
    run_cycles(7, 1'b0, 1'b1, 1'b0);
    run_cycles(2, 1'b1, 1'b1, 1'b0);
    do_reset();
    run_cycles(30, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_count", cycle_count, 32'd0);

    // Randomised phase.
    r_lvl = 1'b0; s_lvl = 1'b0; r_hold = 0; s_hold = 0; h_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic h;
      if (r_hold == 0) begin
        r_lvl = 1'($urandom_range(0, 1));
        r_hold = $urandom_range(1, 14);
      end
      if (s_hold == 0) begin
        s_lvl = 1'($urandom_range(0, 1));
        s_hold = $urandom_range(1, 14);
      end
      r_hold--;
      s_hold--;
      h = !h_prev && ($urandom_range(0, 15) == 0);
      h_prev = h;
      cycle(r_lvl, s_lvl, h);
      if ($urandom_range(0, 699) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
